rom_loader: RTL and testbench

Boot-time program writer for the instruction ROM that the PC-driven fetch path reads.
- Accepts a byte stream over a valid/ready handshake: a 16-bit word count followed by that many 16-bit instruction words.
- Writes each word to consecutive ROM addresses starting at 0.
- Holds the CPU (PC included) in reset until the image is complete.
- Sits between the host/serial front end and the ROM write port.

---
 rtl/rom_loader_pkg.sv | 21 ++
 rtl/rom_loader_asm.sv | 36 +++
 rtl/rom_loader.sv | 150 +++++++++++++++
 tb/tb_rom_loader.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_loader_pkg.sv
// Shared definitions for the boot-time ROM loader.
//   state_t        : loader FSM encoding (3 bits)
//   BYTES_PER_WORD : stream bytes per instruction word
//   WORD_W         : assembled word width in bits
package rom_loader_pkg;

  localparam int BYTES_PER_WORD = 2;
  localparam int WORD_W         = 8 * BYTES_PER_WORD;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_HI  = 3'd1,
    LEN_LO  = 3'd2,
    DATA_HI = 3'd3,
    DATA_LO = 3'd4,
    WRITE   = 3'd5,
    DONE    = 3'd6,
    ERR     = 3'd7
  } state_t;

endpackage

// File: rtl/rom_loader_asm.sv
// Byte-pair assembler: joins a big-endian pair of stream bytes into one word.
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   byte_in     : stream byte
//   strobe      : byte_in is being transferred this cycle
//   phase       : 0 = high byte, 1 = low byte
//   word        : {held high byte, byte_in}; meaningful when word_valid=1
//   word_valid  : low byte transfers this cycle, word is complete
module rom_loader_asm
  import rom_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        byte_in,
  input  logic              strobe,
  input  logic              phase,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  logic [7:0] hi_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_reg <= 8'h00;
    end else if (strobe && !phase) begin
      hi_reg <= byte_in;
    end
  end

  // The low byte is combined straight from the input so the word is ready
  // on the same edge the low byte transfers.
  assign word       = {hi_reg, byte_in};
  assign word_valid = strobe && phase;

endmodule

// File: rtl/rom_loader.sv
// Boot-time program writer for the instruction ROM.
// Receives a big-endian 16-bit word count followed by that many 16-bit
// instruction words over a byte valid/ready handshake, writes them to
// consecutive ROM addresses from 0, and holds the CPU in reset until done.
// Ports:
//   clk, reset          : clock and synchronous active-high reset
//   start               : begin a load (honoured in IDLE, DONE, ERR)
//   byte_in/byte_valid  : stream byte and its valid
//   byte_ready          : loader accepts a byte this cycle
//   wr_en/wr_addr/wr_data : ROM write port, one-cycle strobe per word
//   cpu_reset           : CPU/PC reset, low only in DONE
//   done / error        : image complete / declared length too large
//   word_count          : words written in the current load
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [15:0]       word_count
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_W;

  state_t            state_reg;
  logic [15:0]       len_reg;
  logic              xfer;
  logic              asm_phase;
  logic [WORD_W-1:0] asm_word;
  logic              asm_valid;
  logic [15:0]       count_next;

  assign xfer       = byte_valid && byte_ready;
  assign asm_phase  = (state_reg == LEN_LO) || (state_reg == DATA_LO);
  assign count_next = word_count + 16'd1;

  rom_loader_asm u_asm (
    .clk        (clk),
    .reset      (reset),
    .byte_in    (byte_in),
    .strobe     (xfer),
    .phase      (asm_phase),
    .word       (asm_word),
    .word_valid (asm_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      len_reg    <= 16'd0;
      byte_ready <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= 16'd0;
    end else begin
      wr_en <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg  <= LEN_HI;
            byte_ready <= 1'b1;
            word_count <= 16'd0;
            wr_addr    <= '0;
          end
        end

        LEN_HI: begin
          if (xfer) state_reg <= LEN_LO;
        end

        LEN_LO: begin
          if (asm_valid) begin
            len_reg <= asm_word;
            if (asm_word == 16'd0) begin
              state_reg  <= DONE;
              byte_ready <= 1'b0;
              done       <= 1'b1;
              cpu_reset  <= 1'b0;
            end else if (32'(asm_word) > DEPTH) begin
              state_reg  <= ERR;
              byte_ready <= 1'b0;
              error      <= 1'b1;
            end else begin
              state_reg <= DATA_HI;
            end
          end
        end

        DATA_HI: begin
          if (xfer) state_reg <= DATA_LO;
        end

        DATA_LO: begin
          if (asm_valid) begin
            wr_data    <= DATA_W'(asm_word);
            wr_en      <= 1'b1;
            byte_ready <= 1'b0;
            state_reg  <= WRITE;
          end
        end

        WRITE: begin
          // Address wraps to 0 after DEPTH-1 only for a full-depth image;
          // that wrapped value is never used for a write.
          word_count <= count_next;
          wr_addr    <= wr_addr + ADDR_W'(1);
          if (count_next == len_reg) begin
            state_reg <= DONE;
            done      <= 1'b1;
            cpu_reset <= 1'b0;
          end else begin
            state_reg  <= DATA_HI;
            byte_ready <= 1'b1;
          end
        end

        DONE, ERR: begin
          if (start) begin
            state_reg  <= LEN_HI;
            byte_ready <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_reset  <= 1'b1;
            word_count <= 16'd0;
            wr_addr    <= '0;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Scoreboard bench for rom_loader (ADDR_W=4, DEPTH=16).
module tb_rom_loader;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        byte_in = 8'h00;
  logic              byte_valid = 1'b0;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              cpu_reset;
  logic              done;
  logic              error;
  logic [15:0]       word_count;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t exp_q[$];

  rom_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("[TB] ok %s = 0x%0h", name, act);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: addr %0d data 0x%04h with empty scoreboard", wr_addr, wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (wr_addr !== e.addr || wr_data !== e.data) begin
          fails++;
          $display("FAIL rom_write: got addr %0d data 0x%04h expected addr %0d data 0x%04h",
                   wr_addr, wr_data, e.addr, e.data);
        end else begin
          $display("[TB] write addr %0d data 0x%04h", wr_addr, wr_data);
        end
      end
    end
  end

  // Present a byte and hold it until the loader takes it.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (byte_ready === 1'b1) break;
      n++;
      if (n > 50) begin
        tests++;
        fails++;
        $display("FAIL byte_ready_timeout: byte 0x%02h never accepted", b);
        byte_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic gap();
    byte_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int addr, input logic [15:0] data);
    wr_t e;
    e.addr = ADDR_W'(addr);
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_wr_en"},      32'(wr_en),      32'd0);
    chk({tag, "_wr_addr"},    32'(wr_addr),    32'd0);
    chk({tag, "_wr_data"},    32'(wr_data),    32'd0);
    chk({tag, "_cpu_reset"},  32'(cpu_reset),  32'd1);
    chk({tag, "_done"},       32'(done),       32'd0);
    chk({tag, "_error"},      32'(error),      32'd0);
    chk({tag, "_word_count"}, 32'(word_count), 32'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_reset_vals("reset");

    // Basic load: 00 02 | 12 34 | AB CD
    pulse_start();
    chk("basic_ready_after_start", 32'(byte_ready), 32'd1);
    push(0, 16'h1234);
    push(1, 16'hABCD);
    send(8'h00); send(8'h02);
    send(8'h12); send(8'h34);
    send(8'hAB); send(8'hCD);
    chk("basic_done_in_write", 32'(done), 32'd0);
    chk("basic_cpu_reset_in_write", 32'(cpu_reset), 32'd1);
    wait_cycle();
    chk("basic_done", 32'(done), 32'd1);
    chk("basic_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("basic_word_count", 32'(word_count), 32'd2);

    // Zero length: done on the cycle after the second length byte
    pulse_start();
    chk("restart_done_cleared", 32'(done), 32'd0);
    chk("restart_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("restart_word_count", 32'(word_count), 32'd0);
    send(8'h00); send(8'h00);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("zero_word_count", 32'(word_count), 32'd0);

    // Overflow: length 17 > DEPTH 16
    pulse_start();
    send(8'h00); send(8'h11);
    chk("ovf_error", 32'(error), 32'd1);
    chk("ovf_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("ovf_done", 32'(done), 32'd0);
    repeat (3) wait_cycle();
    pulse_start();
    chk("ovf_error_cleared", 32'(error), 32'd0);
    push(0, 16'h0007);
    send(8'h00); send(8'h01);
    send(8'h00); send(8'h07);
    wait_cycle();
    chk("ovf_reload_done", 32'(done), 32'd1);

    // Back-pressure and gaps; send() keeps byte_valid high through WRITE
    pulse_start();
    push(0, 16'h1122);
    push(1, 16'h3344);
    push(2, 16'h5566);
    send(8'h00); gap(); send(8'h03);
    send(8'h11); gap(); send(8'h22);
    send(8'h33); gap(); gap(); send(8'h44);
    gap(); send(8'h55); send(8'h66);
    wait_cycle();
    chk("bp_done", 32'(done), 32'd1);
    chk("bp_word_count", 32'(word_count), 32'd3);

    // Reset mid-load after 3 data bytes
    pulse_start();
    push(0, 16'hAABB);
    send(8'h00); send(8'h02);
    send(8'hAA); send(8'hBB); send(8'hCC);
    reset = 1'b1;
    wait_cycle();
    reset = 1'b0;
    chk_reset_vals("midreset");
    pulse_start();
    push(0, 16'h5AA5);
    send(8'h00); send(8'h01);
    send(8'h5A); send(8'hA5);
    wait_cycle();
    chk("midreset_reload_done", 32'(done), 32'd1);
    chk("midreset_reload_count", 32'(word_count), 32'd1);

    // Restart from DONE with a full-depth image (len == DEPTH)
    pulse_start();
    chk("full_done_cleared", 32'(done), 32'd0);
    chk("full_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("full_word_count_cleared", 32'(word_count), 32'd0);
    send(8'h00); send(8'h10);
    for (int i = 0; i < 16; i++) begin
      push(i, 16'hC000 + 16'(i * 3));
      send(8'hC0);
      send(8'(i * 3));
    end
    wait_cycle();
    chk("full_done", 32'(done), 32'd1);
    chk("full_error", 32'(error), 32'd0);
    chk("full_word_count", 32'(word_count), 32'd16);
    chk("full_addr_wrapped", 32'(wr_addr), 32'd0);

    repeat (4) wait_cycle();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
